// File: rtl/adder_share_arb.sv
// One registered WIDTH-bit adder shared by NREQ valid/ready requesters.
// Round-robin grant; results leave through a single backpressured output register.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        op_count
);

  // Flat lane packing matches a packed [lane][bit] array bit-for-bit.
  logic [NREQ-1:0][WIDTH-1:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_sum_q,   rsp_sum_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]   ptr_q,       ptr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              can_accept;
  logic              accept;
  logic [WIDTH:0]    full_sum;
  int                idx;

  // Rotating priority search starting at ptr; depends only on valids and ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = gnt_found && can_accept && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = accept && (gnt_idx == ID_W'(i));
  end

  assign full_sum = {1'b0, a_lane[gnt_idx]} + {1'b0, b_lane[gnt_idx]};

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = full_sum[WIDTH-1:0];
      rsp_carry_d = full_sum[WIDTH];
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed vector table, hand sequences for
// backpressure / reset / saturation, then random traffic against a reference model.
module tb_adder_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [ID_W-1:0]       rsp_id;
  logic [CNT_W-1:0]      op_count;

  int n_tests = 0;
  int n_fail  = 0;

  adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [3:0]       v;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic             rr;
    logic [3:0]       e_rdy;
    logic             e_vld;
    logic [7:0]       e_sum;
    logic             e_cy;
    logic [1:0]       e_id;
    logic [3:0]       e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [31:0] a, logic [31:0] b,
                              logic rr, logic [3:0] e_rdy, logic e_vld, logic [7:0] e_sum,
                              logic e_cy, logic [1:0] e_id, logic [3:0] e_cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.b = b; t.rr = rr;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_sum = e_sum;
    t.e_cy = e_cy; t.e_id = e_id; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational grant, clock, check registers.
  task automatic apply_vec(input string tag, input vec_t t);
    reset     = t.rst;
    req_valid = t.v;
    req_a     = t.a;
    req_b     = t.b;
    rsp_ready = t.rr;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(t.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(t.e_vld));
    chk({tag, " rsp_sum"},   32'(rsp_sum),   32'(t.e_sum));
    chk({tag, " rsp_carry"}, 32'(rsp_carry), 32'(t.e_cy));
    chk({tag, " rsp_id"},    32'(rsp_id),    32'(t.e_id));
    chk({tag, " op_count"},  32'(op_count),  32'(t.e_cnt));
  endtask

  vec_t tbl[$];

  // Reference model state
  int              m_ptr, m_cnt;
  logic            m_vld, m_cy;
  logic [7:0]      m_sum;
  logic [1:0]      m_id;
  logic [3:0]      pend;
  logic [3:0][7:0] pa, pb;

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset with all requesters valid, then round-robin, carry, drain
    tbl.push_back(mk(1, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 4'd0));
    tbl.push_back(mk(1, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 4'd0));
    tbl.push_back(mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0001, 1, 8'h11, 0, 2'd0, 4'd1));
    tbl.push_back(mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0010, 1, 8'h12, 0, 2'd1, 4'd2));
    tbl.push_back(mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0100, 1, 8'h13, 0, 2'd2, 4'd3));
    tbl.push_back(mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b1000, 1, 8'h14, 0, 2'd3, 4'd4));
    tbl.push_back(mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'b0001, 1, 8'h11, 0, 2'd0, 4'd5));
    tbl.push_back(mk(0, 4'b0100, 32'h00FF0000, 32'h00010000, 1, 4'b0100, 1, 8'h00, 1, 2'd2, 4'd6));
    tbl.push_back(mk(0, 4'b0100, 32'h00800000, 32'h007F0000, 1, 4'b0100, 1, 8'hFF, 0, 2'd2, 4'd7));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 8'hFF, 0, 2'd2, 4'd7));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++)
      apply_vec($sformatf("tbl%0d", i), tbl[i]);

    // Backpressure: requesters 1 and 3, five stalled cycles, then resume
    apply_vec("bp_load", mk(0, 4'b1010, 32'h30000500, 32'h01000600, 0, 4'b1000, 1, 8'h31, 0, 2'd3, 4'd8));
    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("bp_stall%0d", i),
                mk(0, 4'b1010, 32'h40000500, 32'h02000600, 0, 4'b0000, 1, 8'h31, 0, 2'd3, 4'd8));
    apply_vec("bp_resume1", mk(0, 4'b1010, 32'h40000500, 32'h02000600, 1, 4'b0010, 1, 8'h0B, 0, 2'd1, 4'd9));
    apply_vec("bp_resume3", mk(0, 4'b1000, 32'h40000500, 32'h02000600, 1, 4'b1000, 1, 8'h42, 0, 2'd3, 4'd10));
    apply_vec("bp_drain",   mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 8'h42, 0, 2'd3, 4'd10));

    // Reset while a stalled result is pending
    apply_vec("mr_load",  mk(0, 4'b0100, 32'h00010000, 32'h00020000, 0, 4'b0100, 1, 8'h03, 0, 2'd2, 4'd11));
    apply_vec("mr_stall", mk(0, 4'b0000, 32'h0, 32'h0, 0, 4'b0000, 1, 8'h03, 0, 2'd2, 4'd11));
    apply_vec("mr_reset", mk(1, 4'hF, 32'h04030201, 32'h10101010, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 4'd0));
    apply_vec("mr_after", mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 4'd0));

    // Counter saturation: 20 accepts, grant resumes from requester 0
    for (int n = 1; n <= 20; n++)
      apply_vec($sformatf("sat%0d", n),
                mk(0, 4'hF, 32'h04030201, 32'h10101010, 1, 4'(1 << ((n - 1) % 4)), 1,
                   8'(8'h11 + (n - 1) % 4), 0, 2'((n - 1) % 4), 4'(n > 15 ? 15 : n)));

    // Random traffic against the reference model
    pend = '0; pa = '0; pb = '0;
    for (int c = 0; c < 500; c++) begin
      logic       r, rr, acc;
      logic [3:0] er;
      logic [8:0] s;
      int         g;
      r  = (c == 0) || ($urandom_range(39) == 0);
      rr = ($urandom_range(9) < 7);
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = 8'($urandom);
          pb[i]   = 8'($urandom);
        end
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      acc = (g >= 0) && (!m_vld || rr) && !r;
      er  = acc ? 4'(1 << g) : 4'b0000;
      if (r) begin
        m_ptr = 0; m_cnt = 0; m_vld = 0; m_sum = 0; m_cy = 0; m_id = 0;
      end else if (acc) begin
        s     = {1'b0, pa[g]} + {1'b0, pb[g]};
        m_sum = s[7:0];
        m_cy  = s[8];
        m_id  = 2'(g);
        m_vld = 1'b1;
        m_ptr = (g + 1) % 4;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else if (m_vld && rr) begin
        m_vld = 1'b0;
      end
      apply_vec($sformatf("rnd%0d", c),
                mk(r, pend, pa, pb, rr, er, m_vld, m_sum, m_cy, m_id, 4'(m_cnt)));
      if (acc) pend[g] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
